// File: rtl/axis_route_lock_if.sv
// AXI-Stream style handshake bundle used on both sides of axis_route_lock.
//   tvalid/tready : handshake
//   tdata         : payload, DATA_WIDTH bits
//   tlast         : end-of-packet marker
// Modports: m drives a stream, s receives one.
interface axis_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  tvalid;
  logic                  tready;
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tlast;

  modport m (output tvalid, output tdata, output tlast, input  tready);
  modport s (input  tvalid, input  tdata, input  tlast, output tready);
endinterface

// File: rtl/axis_route_lock.sv
// Packet-aware routing front-end for an AXI-Stream channel demux.
// The destination is decoded from the header beat of each packet and locked
// until TLAST. Beats pass through a 2-entry registered skid buffer that also
// carries the route, so ctrl/en stay aligned with every output beat. Packets
// with an out-of-range destination are discarded and counted.
// Ports:
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset
//   in       : upstream stream (slave side)
//   out      : stream to the demux (master side)
//   en       : demux enable, equals out.tvalid
//   ctrl     : demux select for the current out beat
//   drop_cnt : saturating count of dropped packets
module axis_route_lock #(
  parameter int CHANNEL_NUMBER       = 5,
  parameter int CHANNEL_NUMBER_WIDTH = $clog2(CHANNEL_NUMBER),
  parameter int DATA_WIDTH           = 32,
  parameter int ROUTE_LSB            = 0,
  parameter int DROP_CNT_WIDTH       = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  axis_if.s                               in,
  axis_if.m                               out,
  output logic                            en,
  output logic [CHANNEL_NUMBER_WIDTH-1:0] ctrl,
  output logic [DROP_CNT_WIDTH-1:0]       drop_cnt
);

  localparam logic [1:0] HEAD = 2'd0;
  localparam logic [1:0] BODY = 2'd1;
  localparam logic [1:0] DROP = 2'd2;

  // One extra bit so CHANNEL_NUMBER == 2**W is representable.
  localparam logic [CHANNEL_NUMBER_WIDTH:0] CH_LIMIT =
    (CHANNEL_NUMBER_WIDTH+1)'(CHANNEL_NUMBER);

  typedef logic [CHANNEL_NUMBER_WIDTH-1:0] route_t;

  // Skid buffer storage
  logic [DATA_WIDTH-1:0] mem_data  [2];
  logic                  mem_last  [2];
  route_t                mem_route [2];
  logic                  rd_ptr;
  logic                  wr_ptr;
  logic [1:0]            count;
  logic [1:0]            count_next;
  logic                  ready_q;

  // Packet tracking
  logic [1:0] state;
  logic [1:0] state_next;
  route_t     route_q;
  route_t     push_route;
  route_t     field;
  route_t     ctrl_hold;
  logic       dest_ok;
  logic       accept;
  logic       push;
  logic       pop;
  logic       drop;

  // Forced low while rst is high so nothing is accepted in the reset cycle;
  // otherwise purely registered from the previous cycle's occupancy.
  assign in.tready = ready_q & ~rst;

  assign accept = in.tvalid & in.tready;
  assign pop    = out.tvalid & out.tready;

  assign field   = in.tdata[ROUTE_LSB +: CHANNEL_NUMBER_WIDTH];
  assign dest_ok = ({1'b0, field} < CH_LIMIT);

  always_comb begin
    push       = 1'b0;
    drop       = 1'b0;
    state_next = state;
    push_route = route_q;
    if (accept) begin
      case (state)
        HEAD: begin
          if (dest_ok) begin
            push       = 1'b1;
            push_route = field;
            if (!in.tlast) state_next = BODY;
          end else begin
            drop = 1'b1;
            if (!in.tlast) state_next = DROP;
          end
        end
        BODY: begin
          push = 1'b1;
          if (in.tlast) state_next = HEAD;
        end
        DROP: begin
          if (in.tlast) state_next = HEAD;
        end
        default: state_next = HEAD;
      endcase
    end
  end

  assign count_next = count + {1'b0, push} - {1'b0, pop};

  // Output side reads straight from the head register.
  assign out.tvalid = (count != 2'd0);
  assign out.tdata  = mem_data[rd_ptr];
  assign out.tlast  = mem_last[rd_ptr];
  assign en         = out.tvalid;
  // With an empty buffer the select keeps its last driven value.
  assign ctrl       = out.tvalid ? mem_route[rd_ptr] : ctrl_hold;

  always_ff @(posedge clk) begin
    if (rst) begin
      count     <= '0;
      rd_ptr    <= 1'b0;
      wr_ptr    <= 1'b0;
      ready_q   <= 1'b1;
      state     <= HEAD;
      route_q   <= '0;
      ctrl_hold <= '0;
      drop_cnt  <= '0;
    end else begin
      count     <= count_next;
      ready_q   <= (count_next != 2'd2);
      state     <= state_next;
      ctrl_hold <= ctrl;
      if (push) begin
        wr_ptr  <= ~wr_ptr;
        route_q <= push_route;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      if (drop && (drop_cnt != '1)) drop_cnt <= drop_cnt + 1'b1;
    end
  end

  // Payload storage needs no reset; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr]  <= in.tdata;
      mem_last[wr_ptr]  <= in.tlast;
      mem_route[wr_ptr] <= push_route;
    end
  end

endmodule

// File: tb/tb_axis_route_lock.sv
module tb_axis_route_lock;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en;
  logic [2:0]  ctrl;
  logic [15:0] drop_cnt;

  axis_if #(.DATA_WIDTH(32)) in_if ();
  axis_if #(.DATA_WIDTH(32)) out_if ();

  axis_route_lock #(
    .CHANNEL_NUMBER(5),
    .CHANNEL_NUMBER_WIDTH(3),
    .DATA_WIDTH(32),
    .ROUTE_LSB(0),
    .DROP_CNT_WIDTH(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in(in_if),
    .out(out_if),
    .en(en),
    .ctrl(ctrl),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic [2:0]  ctrl;
  } exp_t;

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic [2:0]  ctrl;
    logic        en;
    int          cyc;
  } obs_t;

  exp_t exp_q[$];
  obs_t obs_q[$];
  int   acc_q[$];
  int   checks = 0;
  int   passes = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Collects completed output handshakes; comparisons live in the tasks.
  always @(negedge clk)
    if (!rst && out_if.tvalid === 1'b1 && out_if.tready === 1'b1)
      obs_q.push_back('{out_if.tdata, out_if.tlast, ctrl, en, cyc});

  task automatic clear_queues();
    exp_q.delete();
    obs_q.delete();
    acc_q.delete();
  endtask

  // Called at posedge+1; returns at posedge+1 after the beat is accepted,
  // with tvalid left high so consecutive calls give a gapless stream.
  task automatic send_beat(input logic [31:0] d, input logic l,
                           input bit fwd, input logic [2:0] c);
    int t;
    in_if.tvalid = 1'b1;
    in_if.tdata  = d;
    in_if.tlast  = l;
    if (fwd) exp_q.push_back('{d, l, c});
    t = 0;
    while (1) begin
      @(negedge clk);
      if (in_if.tready === 1'b1) begin
        acc_q.push_back(cyc);
        break;
      end
      t++;
      if (t > 200) begin
        checks++;
        $display("FAIL send_timeout: tready stuck at %b, required 1", in_if.tready);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_if.tvalid = 1'b0;
    in_if.tdata  = '0;
    in_if.tlast  = 1'b0;
  endtask

  task automatic wait_out(input int n);
    int t;
    t = 0;
    while (obs_q.size() < n && t < 100) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    out_if.tready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (in_if.tready !== 1'b0) $display("FAIL rst_tready: got %b want 0", in_if.tready); else passes++;
    checks++; if (out_if.tvalid !== 1'b0) $display("FAIL rst_tvalid: got %b want 0", out_if.tvalid); else passes++;
    checks++; if (en !== 1'b0) $display("FAIL rst_en: got %b want 0", en); else passes++;
    checks++; if (ctrl !== 3'd0) $display("FAIL rst_ctrl: got %0d want 0", ctrl); else passes++;
    checks++; if (drop_cnt !== 16'd0) $display("FAIL rst_drop_cnt: got %0d want 0", drop_cnt); else passes++;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (in_if.tready !== 1'b1) $display("FAIL post_rst_tready: got %b want 1", in_if.tready); else passes++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single_packet();
    obs_t o; exp_t e; int a; int n;
    clear_queues();
    out_if.tready = 1'b1;
    send_beat(32'h1111_1003, 1'b0, 1'b1, 3'd3);
    send_beat(32'h2222_2005, 1'b0, 1'b1, 3'd3);
    send_beat(32'h3333_3000, 1'b0, 1'b1, 3'd3);
    send_beat(32'h4444_4007, 1'b1, 1'b1, 3'd3);
    idle();
    n = exp_q.size();
    wait_out(n);
    checks++; if (obs_q.size() !== n) $display("FAIL single_count: got %0d want %0d", obs_q.size(), n); else passes++;
    while (obs_q.size() > 0 && exp_q.size() > 0 && acc_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); a = acc_q.pop_front();
      checks++;
      if (o.data !== e.data || o.last !== e.last || o.ctrl !== e.ctrl || o.en !== 1'b1)
        $display("FAIL single_beat: got d=%h l=%b c=%0d en=%b want d=%h l=%b c=%0d en=1",
                 o.data, o.last, o.ctrl, o.en, e.data, e.last, e.ctrl);
      else passes++;
      checks++;
      if (o.cyc !== a + 1) $display("FAIL single_latency: got cycle %0d want %0d", o.cyc, a + 1); else passes++;
    end
    checks++; if (dut.state !== 2'd0) $display("FAIL single_fsm_head: got %0d want 0", dut.state); else passes++;
  endtask

  task automatic test_back_to_back();
    obs_t o; exp_t e; int n; int c0; int i;
    clear_queues();
    out_if.tready = 1'b1;
    send_beat(32'hA000_0001, 1'b0, 1'b1, 3'd1);
    send_beat(32'hA000_0104, 1'b1, 1'b1, 3'd1);
    send_beat(32'hB000_0004, 1'b1, 1'b1, 3'd4);
    idle();
    n = exp_q.size();
    wait_out(n);
    checks++; if (obs_q.size() !== n) $display("FAIL b2b_count: got %0d want %0d", obs_q.size(), n); else passes++;
    c0 = (obs_q.size() > 0) ? obs_q[0].cyc : 0;
    i = 0;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      checks++;
      if (o.data !== e.data || o.last !== e.last || o.ctrl !== e.ctrl || o.cyc !== c0 + i)
        $display("FAIL b2b_beat%0d: got d=%h c=%0d cyc=%0d want d=%h c=%0d cyc=%0d",
                 i, o.data, o.ctrl, o.cyc, e.data, e.ctrl, c0 + i);
      else passes++;
      i++;
    end
    checks++; if (drop_cnt !== 16'd0) $display("FAIL b2b_drop_cnt: got %0d want 0", drop_cnt); else passes++;
  endtask

  task automatic test_drop();
    obs_t o; exp_t e; int n;
    clear_queues();
    out_if.tready = 1'b1;
    send_beat(32'hDEAD_0006, 1'b0, 1'b0, 3'd0);
    send_beat(32'hDEAD_0102, 1'b0, 1'b0, 3'd0);
    send_beat(32'hDEAD_0201, 1'b1, 1'b0, 3'd0);
    idle();
    checks++; if (drop_cnt !== 16'd1) $display("FAIL drop_cnt_first: got %0d want 1", drop_cnt); else passes++;
    // dest 5 is the first invalid code for five channels
    send_beat(32'hDEAD_0305, 1'b1, 1'b0, 3'd0);
    send_beat(32'hC000_0002, 1'b0, 1'b1, 3'd2);
    send_beat(32'hC000_0106, 1'b1, 1'b1, 3'd2);
    idle();
    n = exp_q.size();
    wait_out(n);
    checks++; if (obs_q.size() !== n) $display("FAIL drop_count_out: got %0d want %0d", obs_q.size(), n); else passes++;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      checks++;
      if (o.data !== e.data || o.last !== e.last || o.ctrl !== e.ctrl)
        $display("FAIL drop_beat: got d=%h c=%0d want d=%h c=%0d", o.data, o.ctrl, e.data, e.ctrl);
      else passes++;
    end
    checks++; if (drop_cnt !== 16'd2) $display("FAIL drop_cnt_total: got %0d want 2", drop_cnt); else passes++;
  endtask

  task automatic test_body_field_ignored();
    obs_t o; exp_t e; int n; logic [15:0] d0;
    clear_queues();
    out_if.tready = 1'b1;
    d0 = drop_cnt;
    send_beat(32'h5100_0002, 1'b0, 1'b1, 3'd2);
    send_beat(32'h5200_0007, 1'b0, 1'b1, 3'd2);
    send_beat(32'h5300_0005, 1'b0, 1'b1, 3'd2);
    send_beat(32'h5400_0006, 1'b1, 1'b1, 3'd2);
    idle();
    n = exp_q.size();
    wait_out(n);
    checks++; if (obs_q.size() !== n) $display("FAIL body_count: got %0d want %0d", obs_q.size(), n); else passes++;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      checks++;
      if (o.data !== e.data || o.last !== e.last || o.ctrl !== e.ctrl)
        $display("FAIL body_beat: got d=%h c=%0d want d=%h c=%0d", o.data, o.ctrl, e.data, e.ctrl);
      else passes++;
    end
    checks++; if (drop_cnt !== d0) $display("FAIL body_drop_cnt: got %0d want %0d", drop_cnt, d0); else passes++;
  endtask

  task automatic test_backpressure();
    obs_t o; exp_t e; int n;
    clear_queues();
    out_if.tready = 1'b0;
    fork
      begin
        send_beat(32'hF000_0000, 1'b0, 1'b1, 3'd0);
        send_beat(32'hF100_0003, 1'b0, 1'b1, 3'd0);
        send_beat(32'hF200_0007, 1'b0, 1'b1, 3'd0);
        send_beat(32'hF300_0001, 1'b0, 1'b1, 3'd0);
        send_beat(32'hF400_0004, 1'b0, 1'b1, 3'd0);
        send_beat(32'hF500_0002, 1'b1, 1'b1, 3'd0);
        idle();
      end
      begin
        logic [31:0] first; bit seen; int unstable;
        seen = 0; unstable = 0; first = '0;
        repeat (5) begin
          @(negedge clk);
          if (out_if.tvalid === 1'b1) begin
            if (!seen) begin first = out_if.tdata; seen = 1; end
            else if (out_if.tdata !== first || ctrl !== 3'd0 || out_if.tlast !== 1'b0) unstable++;
          end
        end
        checks++; if (in_if.tready !== 1'b0) $display("FAIL bp_tready_low: got %b want 0", in_if.tready); else passes++;
        checks++; if (acc_q.size() !== 2) $display("FAIL bp_buffered: got %0d want 2", acc_q.size()); else passes++;
        checks++; if (out_if.tvalid !== 1'b1 || en !== 1'b1) $display("FAIL bp_valid: got %b/%b want 1/1", out_if.tvalid, en); else passes++;
        checks++; if (first !== 32'hF000_0000) $display("FAIL bp_head: got %h want f0000000", first); else passes++;
        checks++; if (unstable !== 0) $display("FAIL bp_stable: got %0d changes want 0", unstable); else passes++;
        @(posedge clk);
        #1;
        out_if.tready = 1'b1;
      end
    join
    n = exp_q.size();
    wait_out(n);
    checks++; if (obs_q.size() !== n) $display("FAIL bp_count: got %0d want %0d", obs_q.size(), n); else passes++;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      checks++;
      if (o.data !== e.data || o.last !== e.last || o.ctrl !== e.ctrl)
        $display("FAIL bp_beat: got d=%h l=%b c=%0d want d=%h l=%b c=%0d",
                 o.data, o.last, o.ctrl, e.data, e.last, e.ctrl);
      else passes++;
    end
  endtask

  task automatic test_mid_reset();
    obs_t o; exp_t e; int n;
    clear_queues();
    out_if.tready = 1'b0;
    send_beat(32'h7700_0001, 1'b0, 1'b0, 3'd1);
    idle();
    @(negedge clk);
    checks++; if (out_if.tvalid !== 1'b1 || dut.state !== 2'd1)
      $display("FAIL mid_pre: got valid=%b state=%0d want 1/1", out_if.tvalid, dut.state); else passes++;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (out_if.tvalid !== 1'b0) $display("FAIL mid_tvalid: got %b want 0", out_if.tvalid); else passes++;
    checks++; if (en !== 1'b0) $display("FAIL mid_en: got %b want 0", en); else passes++;
    checks++; if (ctrl !== 3'd0) $display("FAIL mid_ctrl: got %0d want 0", ctrl); else passes++;
    checks++; if (drop_cnt !== 16'd0) $display("FAIL mid_drop_cnt: got %0d want 0", drop_cnt); else passes++;
    checks++; if (in_if.tready !== 1'b1) $display("FAIL mid_tready: got %b want 1", in_if.tready); else passes++;
    @(posedge clk);
    #1;
    clear_queues();
    out_if.tready = 1'b1;
    // Upstream still thinks it is mid-packet; these must decode as headers.
    send_beat(32'h7800_0003, 1'b1, 1'b1, 3'd3);
    send_beat(32'h7900_0007, 1'b1, 1'b0, 3'd0);
    idle();
    n = exp_q.size();
    wait_out(n);
    checks++; if (obs_q.size() !== n) $display("FAIL mid_count: got %0d want %0d", obs_q.size(), n); else passes++;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      checks++;
      if (o.data !== e.data || o.ctrl !== e.ctrl)
        $display("FAIL mid_beat: got d=%h c=%0d want d=%h c=%0d", o.data, o.ctrl, e.data, e.ctrl);
      else passes++;
    end
    checks++; if (drop_cnt !== 16'd1) $display("FAIL mid_header_drop: got %0d want 1", drop_cnt); else passes++;
  endtask

  initial begin
    in_if.tvalid  = 1'b0;
    in_if.tdata   = '0;
    in_if.tlast   = 1'b0;
    out_if.tready = 1'b0;
    test_reset();
    test_single_packet();
    test_back_to_back();
    test_drop();
    test_body_field_ignored();
    test_backpressure();
    test_mid_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation time exceeded");
    $fatal(1);
  end

endmodule
